// File: rtl/spi_mnrch_gen_if.sv
// spi_mnrch_gen_if
//   Command/response handshake between an issuing state machine and the
//   SPI monarch.
//   snd    : start request (honoured only while the monarch is idle)
//   cmd    : transmit word, cmd[len-1:0] goes out MSB first
//   len    : bit count (0 or >WIDTH means WIDTH)
//   ss_sel : target slave index (out of range selects slave 0)
//   cpol   : idle SCLK level for this transfer
//   resp   : received word, right-aligned, upper bits zero
//   busy   : high from acceptance until completion
//   done   : sticky completion flag, cleared by the next accepted snd
interface spi_mnrch_gen_if #(
    parameter int WIDTH  = 16,
    parameter int NUM_SS = 2
);
    localparam int LW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(NUM_SS);

    logic             snd;
    logic [WIDTH-1:0] cmd;
    logic [LW-1:0]    len;
    logic [SW-1:0]    ss_sel;
    logic             cpol;
    logic [WIDTH-1:0] resp;
    logic             busy;
    logic             done;

    // master: the issuing state machine; slave: the SPI monarch itself
    modport master (output snd, cmd, len, ss_sel, cpol, input resp, busy, done);
    modport slave  (input snd, cmd, len, ss_sel, cpol, output resp, busy, done);
endinterface

// File: rtl/spi_mnrch_gen.sv
// spi_mnrch_gen
//   Parametrised SPI monarch. One MSB-first full-duplex transfer per
//   accepted snd; per-transfer length, slave select and clock polarity.
//   SCLK period is 2^DIV_BITS clk cycles, front and back porch HALF each.
//   Ports:
//     clk, rst_n : system clock, asynchronous active-low reset
//     bus        : command/response handshake (spi_mnrch_gen_if.slave)
//     MISO       : serial data in
//     SCLK       : serial clock
//     MOSI       : serial data out
//     SS_n       : active-low slave selects, one-hot-low during a transfer
module spi_mnrch_gen #(
    parameter int WIDTH    = 16,
    parameter int DIV_BITS = 5,
    parameter int NUM_SS   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_mnrch_gen_if.slave    bus,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic [NUM_SS-1:0] SS_n
);
    localparam int LW   = $clog2(WIDTH + 1);
    localparam int SW   = $clog2(NUM_SS);
    localparam int HALF = 2 ** (DIV_BITS - 1);

    typedef enum logic [1:0] {IDLE, XFER, BACK} state_t;

    state_t              state, nxt;
    logic [DIV_BITS-1:0] cnt;
    logic [LW-1:0]       len_q, bitcnt;
    logic                cpol_q, miso_q;
    logic [WIDTH-1:0]    sr, resp_q;
    logic [NUM_SS-1:0]   ss_q;
    logic                busy_q, done_q;

    logic                start, cnt_wrap, last_bit, capture, back_end;
    logic [LW-1:0]       eff_len, shamt;
    logic [SW-1:0]       sel_eff;
    logic [WIDTH-1:0]    keep;

    assign start    = (state == IDLE) && bus.snd;
    assign cnt_wrap = (cnt == {DIV_BITS{1'b1}});
    assign last_bit = ((bitcnt + 1'b1) == len_q);
    // Sample two clks after the leading edge so MISO has settled.
    assign capture  = (cnt == DIV_BITS'(HALF + 1));
    assign back_end = (cnt == DIV_BITS'(HALF - 1));

    assign eff_len = (bus.len == '0 || bus.len > LW'(WIDTH)) ? LW'(WIDTH) : bus.len;
    assign sel_eff = ({1'b0, bus.ss_sel} >= (SW + 1)'(NUM_SS)) ? '0 : bus.ss_sel;
    // Left-align the command so cmd[L-1] sits at the MSB of the shifter.
    assign shamt   = LW'(WIDTH) - eff_len;
    // Shift of all-ones by WIDTH yields zero, so L=WIDTH keeps every bit.
    assign keep    = ~({WIDTH{1'b1}} << len_q);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // next-state logic
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.snd) nxt = XFER;
            XFER:    if (cnt_wrap && last_bit) nxt = BACK;
            BACK:    if (back_end) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            len_q  <= '0;
            bitcnt <= '0;
            cpol_q <= 1'b0;
            miso_q <= 1'b0;
            sr     <= '0;
            resp_q <= '0;
            ss_q   <= '1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            len_q  <= eff_len;
            cpol_q <= bus.cpol;
            sr     <= bus.cmd << shamt;
            cnt    <= '0;
            bitcnt <= '0;
            ss_q   <= ~(NUM_SS'(1) << sel_eff);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (state == XFER) begin
            // cnt wraps freely, so the last trailing edge leaves it at 0
            // for the back porch.
            cnt <= cnt + 1'b1;
            if (capture) miso_q <= MISO;
            if (cnt_wrap) begin
                sr     <= {sr[WIDTH-2:0], miso_q};
                bitcnt <= bitcnt + 1'b1;
            end
        end else if (state == BACK) begin
            cnt <= cnt + 1'b1;
            if (back_end) begin
                resp_q <= sr & keep;
                ss_q   <= '1;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    // output logic
    always_comb begin
        SCLK = cpol_q;
        if (state == XFER) SCLK = cpol_q ^ cnt[DIV_BITS-1];
    end

    assign MOSI     = sr[WIDTH-1];
    assign SS_n     = ss_q;
    assign bus.resp = resp_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_spi_mnrch_gen.sv
// tb_spi_mnrch_gen
//   Directed bench for spi_mnrch_gen (WIDTH=16, DIV_BITS=5, NUM_SS=2) with a
//   serf model that answers a preset word and records the MOSI stream.
module tb_spi_mnrch_gen;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       MISO = 1'b0;
    logic       SCLK, MOSI;
    logic [1:0] SS_n;

    int n_tests = 0;
    int n_fail  = 0;

    spi_mnrch_gen_if #(.WIDTH(16), .NUM_SS(2)) bus ();

    spi_mnrch_gen #(.WIDTH(16), .DIV_BITS(5), .NUM_SS(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .MISO (MISO),
        .SCLK (SCLK),
        .MOSI (MOSI),
        .SS_n (SS_n)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // serf model state: written only by the serf process
    int          cur_len  = 16;
    logic        cur_cpol = 1'b0;
    logic [15:0] slv_word = '0;
    logic [15:0] slv_sr   = '0;
    logic [15:0] mosi_cap = '0;
    logic        sel_d    = 1'b0;
    logic        sclk_d   = 1'b0;
    logic        first_seen = 1'b0;
    logic        first_fall = 1'b0;
    int          rises = 0, leads = 0, ss_falls = 0, ss0_low = 0;

    always @(negedge clk) begin
        logic sel;
        sel = ~&SS_n;
        if (sel && !sel_d) begin
            slv_sr     = slv_word << (16 - cur_len);
            MISO       = slv_sr[15];
            mosi_cap   = '0;
            first_seen = 1'b0;
            ss_falls++;
        end else if (sel && SCLK != sclk_d) begin
            if (!first_seen) begin
                first_seen = 1'b1;
                first_fall = !SCLK;
            end
            if (SCLK) rises++;
            if (SCLK != cur_cpol) begin
                mosi_cap = {mosi_cap[14:0], MOSI};
                leads++;
            end else begin
                slv_sr = slv_sr << 1;
                MISO   = slv_sr[15];
            end
        end
        if (!SS_n[0]) ss0_low++;
        sel_d  = sel;
        sclk_d = SCLK;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer from a posedge+1 point. lat is the cycle (T+n) in
    // which done is first seen; -1 if aborted by reset at cycle abort_at.
    task automatic run_xfer(input logic [15:0] c, input logic [4:0] l, input logic s,
                            input logic cp, input logic [15:0] r, input bit pulses,
                            input int abort_at, output int lat, output bit busy_ok);
        cur_len  = (l == 0 || l > 16) ? 16 : int'(l);
        cur_cpol = cp;
        slv_word = r;
        bus.cmd = c; bus.len = l; bus.ss_sel = s; bus.cpol = cp; bus.snd = 1'b1;
        tick();
        bus.snd = 1'b0;
        chk("ss_start",   {30'd0, SS_n}, s ? 32'h1 : 32'h2);
        chk("busy_start", {31'd0, bus.busy}, 32'h1);
        chk("sclk_start", {31'd0, SCLK}, {31'd0, cp});
        lat = 1;
        busy_ok = 1'b1;
        while (!bus.done && lat < 2000) begin
            if (!bus.busy) busy_ok = 1'b0;
            tick();
            lat++;
            bus.snd = pulses && (lat == 5 || lat == 200);
            if (lat == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_sclk", {31'd0, SCLK}, 32'h0);
                chk("abort_mosi", {31'd0, MOSI}, 32'h0);
                chk("abort_ss",   {30'd0, SS_n}, 32'h3);
                chk("abort_busy", {31'd0, bus.busy}, 32'h0);
                chk("abort_done", {31'd0, bus.done}, 32'h0);
                chk("abort_resp", {16'd0, bus.resp}, 32'h0);
                tick();
                tick();
                rst_n = 1'b1;
                tick();
                lat = -1;
                return;
            end
        end
        bus.snd = 1'b0;
    endtask

    initial begin
        int lat, r0, l0, f0, s0;
        bit bok;
        int d[3];
        int nd, cyc, dw, maxdw, ss_hi;

        rst_n = 1'b0;
        bus.snd = 1'b0; bus.cmd = '0; bus.len = '0; bus.ss_sel = '0; bus.cpol = 1'b0;
        tick(); tick(); tick();
        chk("rst_sclk", {31'd0, SCLK}, 32'h0);
        chk("rst_mosi", {31'd0, MOSI}, 32'h0);
        chk("rst_ss",   {30'd0, SS_n}, 32'h3);
        chk("rst_resp", {16'd0, bus.resp}, 32'h0);
        chk("rst_busy", {31'd0, bus.busy}, 32'h0);
        chk("rst_done", {31'd0, bus.done}, 32'h0);
        rst_n = 1'b1;
        tick(); tick();

        // full width, cpol 0, slave 0
        r0 = rises;
        run_xfer(16'hA5C3, 5'd0, 1'b0, 1'b0, 16'h3C5A, 1'b0, 0, lat, bok);
        chk("t1_lat",   lat, 529);
        chk("t1_resp",  {16'd0, bus.resp}, 32'h3C5A);
        chk("t1_mosi",  {16'd0, mosi_cap}, 32'hA5C3);
        chk("t1_rises", rises - r0, 16);
        chk("t1_ss_end", {30'd0, SS_n}, 32'h3);
        chk("t1_busy_end", {31'd0, bus.busy}, 32'h0);
        chk("t1_busy_held", {31'd0, bok}, 32'h1);
        tick(); tick(); tick();
        chk("t1_done_sticky", {31'd0, bus.done}, 32'h1);
        chk("t1_resp_held", {16'd0, bus.resp}, 32'h3C5A);

        // 8-bit transfer
        r0 = rises;
        run_xfer(16'h12AB, 5'd8, 1'b0, 1'b0, 16'h005E, 1'b0, 0, lat, bok);
        chk("t2_lat",   lat, 273);
        chk("t2_resp",  {16'd0, bus.resp}, 32'h005E);
        chk("t2_mosi",  {16'd0, mosi_cap}, 32'h00AB);
        chk("t2_rises", rises - r0, 8);
        tick(); tick();

        // cpol 1, slave 1
        s0 = ss0_low; l0 = leads;
        run_xfer(16'h1234, 5'd0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 0, lat, bok);
        chk("t3_lat",   lat, 529);
        chk("t3_resp",  {16'd0, bus.resp}, 32'hBEEF);
        chk("t3_mosi",  {16'd0, mosi_cap}, 32'h1234);
        chk("t3_first_fall", {31'd0, first_fall}, 32'h1);
        chk("t3_leads", leads - l0, 16);
        chk("t3_ss0_idle", ss0_low - s0, 0);
        chk("t3_sclk_idle", {31'd0, SCLK}, 32'h1);
        tick(); tick();

        // snd pulses while busy, len above WIDTH
        f0 = ss_falls;
        run_xfer(16'h5AA5, 5'd20, 1'b0, 1'b0, 16'h1234, 1'b1, 0, lat, bok);
        chk("t4_lat",   lat, 529);
        chk("t4_resp",  {16'd0, bus.resp}, 32'h1234);
        chk("t4_single", ss_falls - f0, 1);
        chk("t4_busy_held", {31'd0, bok}, 32'h1);
        tick(); tick();

        // single-bit transfer
        run_xfer(16'h0001, 5'd1, 1'b0, 1'b0, 16'h0001, 1'b0, 0, lat, bok);
        chk("t5_lat",  lat, 49);
        chk("t5_resp", {16'd0, bus.resp}, 32'h0001);
        chk("t5_mosi", {16'd0, mosi_cap}, 32'h0001);
        tick(); tick();

        // reset mid-transfer, then a clean transfer
        run_xfer(16'hFFFF, 5'd0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 100, lat, bok);
        chk("t6_aborted", lat, -1);
        run_xfer(16'h0F0F, 5'd12, 1'b0, 1'b0, 16'h0ABC, 1'b0, 0, lat, bok);
        chk("t6_lat",  lat, 401);
        chk("t6_resp", {16'd0, bus.resp}, 32'h0ABC);
        chk("t6_mosi", {16'd0, mosi_cap}, 32'h0F0F);
        tick(); tick();

        // snd held high: back-to-back 4-bit transfers
        d = '{0, 0, 0};
        nd = 0; cyc = 0; dw = 0; maxdw = 0; ss_hi = 0;
        cur_len = 4; cur_cpol = 1'b0; slv_word = 16'h0009;
        bus.cmd = 16'h000C; bus.len = 5'd4; bus.ss_sel = 1'b0; bus.cpol = 1'b0; bus.snd = 1'b1;
        while (nd < 3 && cyc < 1500) begin
            tick();
            cyc++;
            if (bus.done) begin
                dw++;
                if (dw == 1) begin
                    d[nd] = cyc;
                    nd++;
                    chk("b2b_resp", {16'd0, bus.resp}, 32'h0009);
                end
            end else begin
                dw = 0;
            end
            if (dw > maxdw) maxdw = dw;
            if (nd >= 1 && SS_n == 2'b11) ss_hi++;
        end
        bus.snd = 1'b0;
        chk("b2b_count",  nd, 3);
        chk("b2b_period1", d[1] - d[0], 145);
        chk("b2b_period2", d[2] - d[1], 145);
        chk("b2b_done_w", maxdw, 1);
        chk("b2b_ss_gap", ss_hi, 3);
        chk("b2b_mosi", {16'd0, mosi_cap}, 32'h000C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
